// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction between EX and WB, aligns
// and extends load data from the data SRAM, and drives the WB and forwarding buses.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 121,
    parameter int MS_TO_WS_BUS_WD = 84,
    parameter int MS_TO_DS_BUS_WD = 39
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
    input  logic                       exc_flush,
    input  logic [31:0]                data_sram_rdata
);

    typedef enum logic [2:0] {
        LOAD_NONE = 3'd0,
        LOAD_LB   = 3'd1,
        LOAD_LBU  = 3'd2,
        LOAD_LH   = 3'd3,
        LOAD_LHU  = 3'd4,
        LOAD_LW   = 3'd5,
        LOAD_LWL  = 3'd6,
        LOAD_LWR  = 3'd7
    } load_op_e;

    logic                       ms_valid;
    logic                       ms_ready_go;
    logic [ES_TO_MS_BUS_WD-1:0] ms_bus_r;

    logic [13:0] ms_ctrl;
    logic [2:0]  ms_load_op;
    logic [1:0]  ms_addr_lo;
    logic [31:0] ms_rt_value;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_alu_result;
    logic [31:0] ms_pc;
    logic        ms_es_flush;
    logic        ms_mfc0;

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] final_result;
    logic        fwd_we;
    logic        fwd_is_mfc0;

    assign ms_ctrl       = ms_bus_r[120:107];
    assign ms_es_flush   = ms_bus_r[120];
    assign ms_mfc0       = ms_bus_r[116];
    assign ms_load_op    = ms_bus_r[106:104];
    assign ms_addr_lo    = ms_bus_r[103:102];
    assign ms_rt_value   = ms_bus_r[101:70];
    assign ms_gr_we      = ms_bus_r[69];
    assign ms_dest       = ms_bus_r[68:64];
    assign ms_alu_result = ms_bus_r[63:32];
    assign ms_pc         = ms_bus_r[31:0];

    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !exc_flush;

    // A WB flush wins over a simultaneous handoff from EX.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid <= 1'b0;
        end else if (exc_flush) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_bus_r <= '0;
        end else if (es_to_ms_valid && ms_allowin && !exc_flush) begin
            ms_bus_r <= es_to_ms_bus;
        end
    end

    always_comb begin
        load_byte = data_sram_rdata[7:0];
        case (ms_addr_lo)
            2'd0: load_byte = data_sram_rdata[7:0];
            2'd1: load_byte = data_sram_rdata[15:8];
            2'd2: load_byte = data_sram_rdata[23:16];
            2'd3: load_byte = data_sram_rdata[31:24];
            default: load_byte = data_sram_rdata[7:0];
        endcase
    end

    // Halfword alignment faults are trapped in EX, so addr_lo[0] is don't-care here.
    assign load_half = ms_addr_lo[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];

    always_comb begin
        final_result = ms_alu_result;
        case (load_op_e'(ms_load_op))
            LOAD_NONE: final_result = ms_alu_result;
            LOAD_LB:   final_result = {{24{load_byte[7]}}, load_byte};
            LOAD_LBU:  final_result = {24'd0, load_byte};
            LOAD_LH:   final_result = {{16{load_half[15]}}, load_half};
            LOAD_LHU:  final_result = {16'd0, load_half};
            LOAD_LW:   final_result = data_sram_rdata;
            LOAD_LWL: begin
                case (ms_addr_lo)
                    2'd0: final_result = {data_sram_rdata[7:0],  ms_rt_value[23:0]};
                    2'd1: final_result = {data_sram_rdata[15:0], ms_rt_value[15:0]};
                    2'd2: final_result = {data_sram_rdata[23:0], ms_rt_value[7:0]};
                    default: final_result = data_sram_rdata;
                endcase
            end
            LOAD_LWR: begin
                case (ms_addr_lo)
                    2'd0: final_result = data_sram_rdata;
                    2'd1: final_result = {ms_rt_value[31:24], data_sram_rdata[31:8]};
                    2'd2: final_result = {ms_rt_value[31:16], data_sram_rdata[31:16]};
                    default: final_result = {ms_rt_value[31:8], data_sram_rdata[31:24]};
                endcase
            end
            default: final_result = ms_alu_result;
        endcase
    end

    assign ms_to_ws_bus = {ms_ctrl, ms_gr_we, ms_dest, final_result, ms_pc};

    // An MFC0 result is only known in WB, so decode must stall on a match rather than forward.
    assign fwd_we      = ms_valid && ms_gr_we && !ms_es_flush && (ms_dest != 5'd0);
    assign fwd_is_mfc0 = ms_valid && ms_mfc0;

    assign ms_to_ds_bus = ms_valid ? {fwd_we, fwd_is_mfc0, ms_dest, final_result}
                                   : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed load/forwarding vectors feed a
// scoreboard, and a negedge monitor compares every instruction handed to WB.
module tb_mem_stage;

    logic         clk;
    logic         resetn;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [120:0] es_to_ms_bus;
    logic         ms_to_ws_valid;
    logic [83:0]  ms_to_ws_bus;
    logic [38:0]  ms_to_ds_bus;
    logic         exc_flush;
    logic [31:0]  data_sram_rdata;

    typedef struct {
        logic [83:0] ws;
        logic [38:0] ds;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   waits;

    mem_stage dut (
        .clk            (clk),
        .resetn         (resetn),
        .ws_allowin     (ws_allowin),
        .ms_allowin     (ms_allowin),
        .es_to_ms_valid (es_to_ms_valid),
        .es_to_ms_bus   (es_to_ms_bus),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ms_to_ws_bus   (ms_to_ws_bus),
        .ms_to_ds_bus   (ms_to_ds_bus),
        .exc_flush      (exc_flush),
        .data_sram_rdata(data_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [120:0] mkEs(input logic fl, input logic bd, input logic eret,
                                          input logic sysc, input logic mfc0, input logic mtc0,
                                          input logic [4:0] rd, input logic [2:0] lop,
                                          input logic [1:0] lo, input logic [31:0] rt,
                                          input logic we, input logic [4:0] dest,
                                          input logic [31:0] alu, input logic [31:0] pc);
        return {fl, bd, eret, sysc, mfc0, mtc0, 3'd0, rd, lop, lo, rt, we, dest, alu, pc};
    endfunction

    function automatic logic [83:0] expWs(input logic [120:0] es, input logic [31:0] res);
        return {es[120:107], es[69:64], res, es[31:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one instruction from EX, waits for MS to accept it, then presents its SRAM data.
    task automatic applyStimulus(input logic [120:0] bus, input logic [31:0] rdata,
                                 input logic [31:0] res, input logic we, input logic mf,
                                 input bit expect_out, input bit no_wait);
        exp_t e;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = bus;
        waits = 0;
        @(negedge clk);
        while (!(ms_allowin && !exc_flush)) begin
            waits++;
            if (waits > 50) begin
                errors++;
                $display("[TB] FAIL accept_timeout: got %0d cycles expected <= 50", waits);
                break;
            end
            @(negedge clk);
        end
        if (no_wait) checkOutput("no_bubble", 128'(waits), 128'd0);
        if (expect_out) begin
            e.ws = expWs(bus, res);
            e.ds = {we, mf, bus[68:64], res};
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = rdata;
    endtask

    // Monitor: every WB handoff pops the oldest expectation.
    always @(negedge clk) begin
        if (resetn && ms_to_ws_valid && ws_allowin) begin
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("[TB] FAIL unexpected_output: got pc %0h expected none", ms_to_ws_bus[31:0]);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("ws_bus", 128'(ms_to_ws_bus), 128'(e.ws));
                checkOutput("ds_bus", 128'(ms_to_ds_bus), 128'(e.ds));
            end
        end
    end

    localparam logic [31:0] D1 = 32'h80FF7F01;
    localparam logic [31:0] D2 = 32'h11223344;
    localparam logic [31:0] RT = 32'hAABBCCDD;

    logic [120:0] bus_a;

    initial begin
        resetn = 1'b0;
        ws_allowin = 1'b1;
        es_to_ms_valid = 1'b0;
        es_to_ms_bus = '0;
        exc_flush = 1'b0;
        data_sram_rdata = '0;
        #12;
        checkOutput("reset_ws_valid", 128'(ms_to_ws_valid), 128'd0);
        checkOutput("reset_ds_bus", 128'(ms_to_ds_bus), 128'd0);
        checkOutput("reset_ws_bus", 128'(ms_to_ws_bus), 128'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("reset_allowin", 128'(ms_allowin), 128'd1);
        @(posedge clk);
        #1;

        // Back-to-back byte/half/word loads.
        applyStimulus(mkEs(0,0,0,0,0,0,0,3'd1,2'd3,0, 1,5'd2,32'h1003,32'hBFC00000), D1, 32'hFFFFFF80, 1, 0, 1, 1);
        applyStimulus(mkEs(0,1,0,0,0,0,0,3'd2,2'd3,0, 1,5'd3,32'h1003,32'hBFC00004), D1, 32'h00000080, 1, 0, 1, 1);
        applyStimulus(mkEs(0,0,0,0,0,0,0,3'd3,2'd2,0, 1,5'd4,32'h1002,32'hBFC00008), D1, 32'hFFFF80FF, 1, 0, 1, 1);
        applyStimulus(mkEs(0,0,0,0,0,0,0,3'd4,2'd0,0, 1,5'd5,32'h1000,32'hBFC0000C), D1, 32'h00007F01, 1, 0, 1, 1);
        applyStimulus(mkEs(0,0,0,0,0,0,0,3'd1,2'd0,0, 1,5'd6,32'h1000,32'hBFC00010), D1, 32'h00000001, 1, 0, 1, 1);
        applyStimulus(mkEs(0,0,0,0,0,0,0,3'd3,2'd3,0, 1,5'd7,32'h1003,32'hBFC00014), D1, 32'hFFFF80FF, 1, 0, 1, 1);
        applyStimulus(mkEs(0,0,0,0,0,0,0,3'd6,2'd1,RT,1,5'd9,32'h2001,32'hBFC00018), D2, 32'h3344CCDD, 1, 0, 1, 1);
        applyStimulus(mkEs(0,0,0,0,0,0,0,3'd7,2'd2,RT,1,5'd9,32'h2002,32'hBFC0001C), D2, 32'hAABB1122, 1, 0, 1, 1);
        applyStimulus(mkEs(0,0,0,0,0,0,0,3'd7,2'd0,RT,1,5'd9,32'h2000,32'hBFC00020), D2, 32'h11223344, 1, 0, 1, 1);
        applyStimulus(mkEs(0,0,0,0,0,0,0,3'd6,2'd3,RT,1,5'd9,32'h2003,32'hBFC00024), D2, 32'h11223344, 1, 0, 1, 1);
        applyStimulus(mkEs(0,0,0,0,0,0,0,3'd5,2'd0,0, 1,5'd10,32'h2000,32'hBFC00028), D2, 32'h11223344, 1, 0, 1, 1);

        // Forwarding cases: MFC0, write to $0, flushed instruction.
        applyStimulus(mkEs(0,0,0,0,1,0,5'd12,3'd0,2'd0,0,1,5'd8,32'h0,32'hBFC0002C), D2, 32'h0, 1, 1, 1, 1);
        applyStimulus(mkEs(0,0,0,0,0,0,0,3'd0,2'd0,0,1,5'd0,32'h1234,32'hBFC00030), D2, 32'h1234, 0, 0, 1, 1);
        applyStimulus(mkEs(1,0,1,1,0,1,5'd14,3'd0,2'd0,0,1,5'd5,32'h55,32'hBFC00034), D2, 32'h55, 0, 0, 1, 1);

        // Stall: WB refuses for 3 cycles while EX keeps presenting.
        bus_a = mkEs(0,0,0,0,0,0,0,3'd2,2'd1,0,1,5'd11,32'h3001,32'hBFC00040);
        applyStimulus(bus_a, D1, 32'h0000007F, 1, 0, 1, 1);
        ws_allowin = 1'b0;
        fork
            applyStimulus(mkEs(0,0,0,0,0,0,0,3'd1,2'd2,0,1,5'd12,32'h3002,32'hBFC00044), D1, 32'hFFFFFFFF, 1, 0, 1, 0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("stall_allowin", 128'(ms_allowin), 128'd0);
                    checkOutput("stall_bus_hold", 128'(ms_to_ws_bus), 128'(expWs(bus_a, 32'h0000007F)));
                end
                @(posedge clk);
                #1;
                ws_allowin = 1'b1;
            end
        join
        applyStimulus(mkEs(0,0,0,0,0,0,0,3'd0,2'd0,0,1,5'd13,32'h7777,32'hBFC00048), D1, 32'h7777, 1, 0, 1, 1);

        // Flush collides with a new instruction arriving from EX.
        bus_a = mkEs(0,0,0,0,0,0,0,3'd5,2'd0,0,1,5'd14,32'h4000,32'hBFC00050);
        applyStimulus(bus_a, D2, 32'h11223344, 1, 0, 0, 0);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mkEs(0,0,0,0,0,0,0,3'd0,2'd0,0,1,5'd15,32'h9999,32'hBFC00054);
        exc_flush      = 1'b1;
        @(negedge clk);
        checkOutput("flush_ws_valid_now", 128'(ms_to_ws_valid), 128'd0);
        @(posedge clk);
        #1;
        exc_flush = 1'b0;
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        checkOutput("flush_ws_valid_next", 128'(ms_to_ws_valid), 128'd0);
        checkOutput("flush_allowin_next", 128'(ms_allowin), 128'd1);
        checkOutput("flush_ds_bus", 128'(ms_to_ds_bus), 128'd0);
        checkOutput("flush_bus_kept", 128'(ms_to_ws_bus), 128'(expWs(bus_a, 32'h11223344)));
        @(posedge clk);
        #1;

        // Asynchronous reset while an instruction is stalled.
        ws_allowin = 1'b0;
        applyStimulus(mkEs(0,0,0,0,0,0,0,3'd0,2'd0,0,1,5'd16,32'h5555,32'hBFC00060), D1, 32'h5555, 1, 0, 0, 0);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("midreset_ws_valid", 128'(ms_to_ws_valid), 128'd0);
        checkOutput("midreset_ds_bus", 128'(ms_to_ds_bus), 128'd0);
        checkOutput("midreset_ws_bus", 128'(ms_to_ws_bus), 128'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        ws_allowin = 1'b1;
        @(negedge clk);
        checkOutput("midreset_allowin", 128'(ms_allowin), 128'd1);
        repeat (2) @(negedge clk);
        checkOutput("scoreboard_empty", 128'(sb.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("[TB] FAIL global_timeout: got time %0t expected finish earlier", $time);
        $fatal(1, "timeout");
    end

endmodule
